// File: rtl/hwpe_stream_sink_packer.sv
// Upsizing HWPE-Stream packer: gathers RATIO narrow beats into one registered wide beat,
// flushing early on last with the unwritten lanes strobed off.
module hwpe_stream_sink_packer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 128,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned RATIO    = OUT_WIDTH / IN_WIDTH,
    localparam int unsigned LANE_W   = $clog2(RATIO)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic [IN_WIDTH-1:0]    push_data_i,
    input  logic [IN_WIDTH/8-1:0]  push_strb_i,
    input  logic                   push_last_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    output logic [OUT_WIDTH-1:0]   pop_data_o,
    output logic [OUT_WIDTH/8-1:0] pop_strb_o,
    output logic                   pop_last_o,
    output logic                   pop_valid_o,
    input  logic                   pop_ready_i,
    output logic [LANE_W-1:0]      lane_o,
    output logic [CNT_WIDTH-1:0]   words_o,
    output logic                   done_o
);

    localparam int unsigned IN_SW  = IN_WIDTH / 8;
    localparam int unsigned OUT_SW = OUT_WIDTH / 8;

    logic [LANE_W-1:0]    lane_q;
    logic [OUT_WIDTH-1:0] asm_data_q;
    logic [OUT_SW-1:0]    asm_strb_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [OUT_SW-1:0]    out_strb_q;
    logic                 out_last_q;
    logic                 out_valid_q;
    logic [CNT_WIDTH-1:0] words_q;
    logic                 done_q;

    logic                 completing;
    logic                 accept;
    logic                 pop;
    logic [OUT_WIDTH-1:0] merged_data;
    logic [OUT_SW-1:0]    merged_strb;

    assign completing   = (lane_q == LANE_W'(RATIO - 1)) | push_last_i;
    assign push_ready_o = ~out_valid_q | pop_ready_i | ~completing;
    assign accept       = push_valid_i & push_ready_o;
    assign pop          = out_valid_q & pop_ready_i;

    // Lanes below the fill pointer keep assembled data, the current lane takes
    // the incoming beat, lanes above are forced to zero so a flush strobes them off.
    always_comb begin
        merged_data = '0;
        merged_strb = '0;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (LANE_W'(k) < lane_q) begin
                merged_data[k*IN_WIDTH +: IN_WIDTH] = asm_data_q[k*IN_WIDTH +: IN_WIDTH];
                merged_strb[k*IN_SW +: IN_SW]       = asm_strb_q[k*IN_SW +: IN_SW];
            end else if (LANE_W'(k) == lane_q) begin
                merged_data[k*IN_WIDTH +: IN_WIDTH] = push_data_i;
                merged_strb[k*IN_SW +: IN_SW]       = push_strb_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            lane_q      <= '0;
            asm_data_q  <= '0;
            asm_strb_q  <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            words_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            if (accept) begin
                if (completing) begin
                    out_data_q <= merged_data;
                    out_strb_q <= merged_strb;
                    out_last_q <= push_last_i;
                    asm_data_q <= '0;
                    asm_strb_q <= '0;
                    lane_q     <= '0;
                end else begin
                    asm_data_q <= merged_data;
                    asm_strb_q <= merged_strb;
                    lane_q     <= lane_q + LANE_W'(1);
                end
            end
            // A load in the same cycle as a pop keeps the output full.
            if (accept && completing) begin
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
            if (pop) begin
                words_q <= words_q + CNT_WIDTH'(1);
            end
            done_q <= pop & out_last_q;
        end
    end

    assign pop_data_o  = out_data_q;
    assign pop_strb_o  = out_strb_q;
    assign pop_last_o  = out_last_q;
    assign pop_valid_o = out_valid_q;
    assign lane_o      = lane_q;
    assign words_o     = words_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_hwpe_stream_sink_packer.sv
// Bench for hwpe_stream_sink_packer: queue-based packing model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_hwpe_stream_sink_packer;

    localparam int IN_W  = 32;
    localparam int OUT_W = 128;
    localparam int CNT_W = 16;
    localparam int RATIO = OUT_W / IN_W;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             clear_i = 1'b0;
    logic [IN_W-1:0]  push_data_i = '0;
    logic [IN_W/8-1:0] push_strb_i = '0;
    logic             push_last_i = 1'b0;
    logic             push_valid_i = 1'b0;
    logic             push_ready_o;
    logic [OUT_W-1:0] pop_data_o;
    logic [OUT_W/8-1:0] pop_strb_o;
    logic             pop_last_o;
    logic             pop_valid_o;
    logic             pop_ready_i = 1'b1;
    logic [1:0]       lane_o;
    logic [CNT_W-1:0] words_o;
    logic             done_o;

    hwpe_stream_sink_packer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .push_data_i(push_data_i), .push_strb_i(push_strb_i), .push_last_i(push_last_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .pop_data_o(pop_data_o), .pop_strb_o(pop_strb_o), .pop_last_o(pop_last_o),
        .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
        .lane_o(lane_o), .words_o(words_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic [OUT_W-1:0]   d;
        logic [OUT_W/8-1:0] s;
        logic               l;
    } word_t;

    // Model state: words waiting for the sink (capacity one register), beats gathered so far.
    word_t              mq[$];
    logic [OUT_W-1:0]   part_d;
    logic [OUT_W/8-1:0] part_s;
    int                 part_n;
    int                 mcount;
    logic               mdone;

    logic [OUT_W-1:0]   last_d;
    logic [OUT_W/8-1:0] last_s;
    logic               last_l;

    always @(negedge clk_i) begin
        if (rst_i || clear_i) begin
            mq.delete();
            part_d = '0;
            part_s = '0;
            part_n = 0;
            mcount = 0;
            mdone  = 1'b0;
        end else begin
            bit m_valid, m_pop, m_comp, m_rdy, m_acc;
            int occ;
            word_t w;
            m_valid = (mq.size() != 0);
            m_comp  = (part_n == RATIO - 1) || push_last_i;
            m_pop   = m_valid && pop_ready_i;
            occ     = mq.size() + (m_comp ? 1 : 0) - (m_pop ? 1 : 0);
            m_rdy   = (occ <= 1);
            m_acc   = push_valid_i && m_rdy;

            chk("pop_valid", pop_valid_o, m_valid);
            chk("push_ready", push_ready_o, m_rdy);
            chk("lane", lane_o, part_n);
            chk("words", words_o, 128'(mcount[CNT_W-1:0]));
            chk("done", done_o, mdone);
            if (m_valid) begin
                chk("pop_data", pop_data_o, mq[0].d);
                chk("pop_strb", pop_strb_o, mq[0].s);
                chk("pop_last", pop_last_o, mq[0].l);
            end

            if (pop_valid_o && pop_ready_i) begin
                last_d = pop_data_o;
                last_s = pop_strb_o;
                last_l = pop_last_o;
            end

            mdone = 1'b0;
            if (m_pop) begin
                w = mq.pop_front();
                mcount++;
                mdone = w.l;
            end
            if (m_acc) begin
                part_d = part_d | (OUT_W'(push_data_i) << (part_n * IN_W));
                part_s = part_s | ((OUT_W/8)'(push_strb_i) << (part_n * (IN_W / 8)));
                part_n++;
                if (part_n == RATIO || push_last_i) begin
                    w.d = part_d;
                    w.s = part_s;
                    w.l = push_last_i;
                    mq.push_back(w);
                    part_d = '0;
                    part_s = '0;
                    part_n = 0;
                end
            end
        end
    end

    int stalls;

    task automatic send_beat(input logic [IN_W-1:0] d, input logic [3:0] s, input logic l);
        bit got;
        got = 0;
        push_data_i  = d;
        push_strb_i  = s;
        push_last_i  = l;
        push_valid_i = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i);
            if (push_ready_o) got = 1;
            else stalls++;
            @(posedge clk_i);
            #1;
        end
        if (!got) chk("send_timeout", 0, 1);
        push_valid_i = 1'b0;
        push_last_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
    endtask

    initial begin
        idle(3);
        rst_i = 1'b0;
        idle(1);
        chk("rst_lane", lane_o, 0);
        chk("rst_valid", pop_valid_o, 0);
        chk("rst_words", words_o, 0);

        // Full four-beat burst with last
        pop_ready_i = 1'b1;
        send_beat(32'h11111111, 4'hF, 0);
        send_beat(32'h22222222, 4'hF, 0);
        send_beat(32'h33333333, 4'hF, 0);
        send_beat(32'h44444444, 4'hF, 1);
        chk("t1_valid_next", pop_valid_o, 1);
        idle(1);
        chk("t1_done", done_o, 1);
        idle(2);
        chk("t1_data", last_d, 128'h44444444_33333333_22222222_11111111);
        chk("t1_strb", last_s, 16'hFFFF);
        chk("t1_last", last_l, 1);
        chk("t1_words", words_o, 1);

        // Partial burst flushed on last
        send_beat(32'hA, 4'hF, 0);
        send_beat(32'hB, 4'hF, 0);
        send_beat(32'hC, 4'hF, 1);
        idle(3);
        chk("t2_data", last_d, 128'h00000000_0000000C_0000000B_0000000A);
        chk("t2_strb", last_s, 16'h0FFF);
        chk("t2_last", last_l, 1);
        chk("t2_lane", lane_o, 0);

        // Continuous stream at full throughput
        do_clear();
        stalls = 0;
        for (int i = 0; i < 32; i++) send_beat(32'h1000 + i, 4'hF, 0);
        idle(3);
        chk("t3_stalls", stalls, 0);
        chk("t3_words", words_o, 8);
        chk("t3_data", last_d, 128'h0000101F_0000101E_0000101D_0000101C);

        // Backpressure: output held, completing beat stalls
        pop_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h100 + i, 4'hF, 0);
        for (int i = 0; i < 3; i++) send_beat(32'h200 + i, 4'hF, 0);
        push_data_i  = 32'h203;
        push_strb_i  = 4'hF;
        push_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("t4_stall", push_ready_o, 0);
            chk("t4_hold", pop_data_o, 128'h00000103_00000102_00000101_00000100);
        end
        @(posedge clk_i);
        #1;
        pop_ready_i = 1'b1;
        @(negedge clk_i);
        chk("t4_release", push_ready_o, 1);
        @(posedge clk_i);
        #1;
        push_valid_i = 1'b0;
        chk("t4_valid_kept", pop_valid_o, 1);
        chk("t4_second", pop_data_o, 128'h00000203_00000202_00000201_00000200);
        for (int i = 4; i < 8; i++) send_beat(32'h200 + i, 4'hF, 0);
        idle(3);
        chk("t4_words", words_o, 11);

        // Soft clear mid-burst with a full output
        pop_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h300 + i, 4'hF, 0);
        send_beat(32'h310, 4'hF, 0);
        send_beat(32'h311, 4'hF, 0);
        chk("t5_lane_pre", lane_o, 2);
        chk("t5_valid_pre", pop_valid_o, 1);
        do_clear();
        chk("t5_lane", lane_o, 0);
        chk("t5_valid", pop_valid_o, 0);
        chk("t5_words", words_o, 0);
        pop_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) send_beat(32'h50 + i, 4'hF, 0);
        idle(3);
        chk("t5_data", last_d, 128'h00000054_00000053_00000052_00000051);
        chk("t5_words_after", words_o, 1);

        // Single beat with last and partial strobe
        send_beat(32'hDEADBEEF, 4'h3, 1);
        idle(3);
        chk("t6_data", last_d, 128'h00000000_00000000_00000000_DEADBEEF);
        chk("t6_strb", last_s, 16'h0003);
        chk("t6_last", last_l, 1);
        chk("t6_words", words_o, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
